// File: rtl/upsample_if.sv
// Handshake and data bus of the 2x2 upsampler: 3x3 map in, 6x6 map out.
interface upsample_if #(
    parameter int DATA_W = 8
);
    logic                   upsample_valid_i;
    logic [9*DATA_W-1:0]    upsample_input;
    logic                   upsample_busy_o;
    logic                   upsample_valid_o;
    logic [36*DATA_W-1:0]   upsample_output;

    modport master (
        output upsample_valid_i,
        output upsample_input,
        input  upsample_busy_o,
        input  upsample_valid_o,
        input  upsample_output
    );

    modport slave (
        input  upsample_valid_i,
        input  upsample_input,
        output upsample_busy_o,
        output upsample_valid_o,
        output upsample_output
    );
endinterface

// File: rtl/upsample.sv
// 2x2 upsampler: expands a captured 3x3 map into a 6x6 map, one 2x2 block per cycle.
// Define UPSAMPLE_ZERO_FILL_EN for zero-insertion unpooling; default is replicate mode.
module upsample #(
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    upsample_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [9*DATA_W-1:0]    in_q, in_d;
    logic [36*DATA_W-1:0]   work_q, work_d;
    logic [36*DATA_W-1:0]   out_q, out_d;
    logic                   vld_q, vld_d;
    logic                   busy_q, busy_d;

    // Writes input element blk into its 2x2 block; the other three cells get the fill value.
    function automatic logic [36*DATA_W-1:0] write_block(
        input logic [36*DATA_W-1:0] work,
        input logic [9*DATA_W-1:0]  src,
        input logic [3:0]           blk
    );
        logic [36*DATA_W-1:0] res;
        logic [DATA_W-1:0]    elem;
        logic [DATA_W-1:0]    fill;
        int                   bi;
        int                   base;
        res  = work;
        bi   = int'(blk);
        base = (bi / 3) * 12 + (bi % 3) * 2;
        elem = src[bi*DATA_W +: DATA_W];
`ifdef UPSAMPLE_ZERO_FILL_EN
        fill = '0;
`else
        fill = elem;
`endif
        res[base*DATA_W +: DATA_W]       = elem;
        res[(base+1)*DATA_W +: DATA_W]   = fill;
        res[(base+6)*DATA_W +: DATA_W]   = fill;
        res[(base+7)*DATA_W +: DATA_W]   = fill;
        return res;
    endfunction

    // Next-state and datapath decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_d    = in_q;
        work_d  = work_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.upsample_valid_i) begin
                    in_d    = bus.upsample_input;
                    cnt_d   = 4'd0;
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                work_d = write_block(work_q, in_q, cnt_q);
                // The counter parks at 8 so it never leaves the 0..8 block range.
                if (cnt_q == 4'd8) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                out_d   = work_q;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            in_q    <= '0;
            work_q  <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            work_q  <= work_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.upsample_busy_o  = busy_q;
    assign bus.upsample_valid_o = vld_q;
    assign bus.upsample_output  = out_q;
endmodule

// File: doc/upsample.md
UPSAMPLE -- requirements
Module: upsample

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: bit width of one feature-map element (unsigned).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port upsample_valid_i  input  1  single-cycle pulse: upsample_input holds a 3x3 map.
REQ-005 The block SHALL have port upsample_input  input  9*DATA_W  3x3 map; element k=r*3+c at bits [(k+1)*DATA_W-1 -: DATA_W].
REQ-006 The block SHALL have port upsample_busy_o  output  1  high while a map is being expanded.
REQ-007 The block SHALL have port upsample_valid_o  output  1  single-cycle pulse: upsample_output updated.
REQ-008 The block SHALL have port upsample_output  output  36*DATA_W  6x6 map; element j=R*6+C at bits [(j+1)*DATA_W-1 -: DATA_W].

Function
REQ-009 The block SHALL implement a 2x2 upsampler, the inverse of the 2x2 pooling stage: 3x3 in, 6x6 out.
REQ-010 The FSM SHALL have states IDLE, FILL, DONE; upsample_busy_o SHALL be 1 in FILL and DONE, 0 in IDLE.
REQ-011 In IDLE, an edge with upsample_valid_i=1 SHALL capture upsample_input into an input register, clear the 4-bit block counter to 0, and enter FILL.
REQ-012 In FILL, each edge SHALL write block b=counter (br=b/3, bc=b%3) into the working register at output indices (2br)*6+2bc, +1, +6, and +7, then increment the counter.
REQ-013 With replicate mode, all four written elements of block b SHALL equal input element b.
REQ-014 The edge that writes block 8 SHALL enter DONE; the counter SHALL NOT exceed 8.
REQ-015 In DONE, the next edge SHALL copy the working register to upsample_output, set upsample_valid_o=1, and enter IDLE.
REQ-016 upsample_valid_o SHALL be high for exactly one cycle and SHALL be cleared on the following edge.
REQ-017 Latency: upsample_valid_o SHALL rise on the 10th edge after the capturing edge (1 capture edge, 9 fill edges, 1 output edge).
REQ-018 upsample_output SHALL hold its value between completions; partial results SHALL never be visible on it.
REQ-019 upsample_valid_i while busy_o=1 SHALL be ignored (no capture, no counter change, no error flag).
REQ-020 upsample_valid_i in the cycle that upsample_valid_o is high SHALL be accepted, because the FSM is already in IDLE.
REQ-021 Elements SHALL be copied unmodified; there SHALL be no arithmetic or saturation.

Reset
REQ-022 rst_n low SHALL asynchronously force the FSM to IDLE and the counter to 0.
REQ-023 rst_n low SHALL asynchronously clear the input register, the working register, upsample_output, and upsample_valid_o to 0.
REQ-024 Reset asserted mid-FILL SHALL abandon the map with no upsample_valid_o pulse.
REQ-025 After reset release, the first upsample_valid_i SHALL start a fresh expansion.

Configuration
REQ-026 With macro UPSAMPLE_ZERO_FILL_EN defined, the block SHALL perform zero-insertion unpooling: index (2br)*6+2bc gets input element b, and indices +1, +6, +7 get 0.
REQ-027 Without UPSAMPLE_ZERO_FILL_EN, the block SHALL use replicate mode (REQ-013); timing and the interface SHALL be identical in both modes.

Verification
REQ-028 Reset, then pulse valid_i with elements k=0..8 set to 0x10+k -> busy rises next cycle.
REQ-029 Same stimulus -> valid_o pulses once, 10 edges after capture.
REQ-030 Same stimulus, replicate mode -> output elements 0,1,6,7=0x10; 4,5,10,11=0x12; 28,29,34,35=0x18.
REQ-031 Same stimulus, UPSAMPLE_ZERO_FILL_EN -> element 0=0x10, element 14=0x14, elements 1,6,7=0x00.
REQ-032 Second valid_i with all elements 0xFF at edge 5 of FILL -> ignored; output matches the first map; only one valid_o.
REQ-033 Back-to-back: valid_i with all elements 0xAA during the valid_o cycle -> accepted; second valid_o 10 edges later with all 36 elements 0xAA (replicate).
REQ-034 rst_n pulsed low at fill edge 4 -> output 0, no valid_o, busy_o 0; new valid_i completes normally.
